// File: rtl/kmer_pkg.sv
// Shared definitions for the k-mer extractor: base encodings, FSM states and base helpers.
package kmer_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } kmerState_t;

    // With this encoding the complement of a base is its bitwise inverse.
    function automatic logic [1:0] revcomp_base(input logic [1:0] b);
        return ~b;
    endfunction

endpackage

// File: rtl/kmer_extractor_if.sv
// Base-stream input, k-mer output and per-read status bundle of the k-mer extractor.
interface kmer_extractor_if #(
    parameter int unsigned KMER_WIDTH = 45,
    parameter int unsigned POS_WIDTH  = 16
);
    logic                    baseValid;
    logic                    baseReady;
    logic [1:0]              base;
    logic                    baseN;
    logic                    sop;
    logic                    eop;
    logic [2*KMER_WIDTH-1:0] kmer;
    logic                    kmerValid;
    logic                    kmerReady;
    logic [POS_WIDTH-1:0]    kmerPos;
    logic                    readDone;
    logic [POS_WIDTH-1:0]    readKmerCount;
    logic                    protocolError;

    modport master (
        output baseValid, base, baseN, sop, eop, kmerReady,
        input  baseReady, kmer, kmerValid, kmerPos, readDone, readKmerCount, protocolError
    );

    modport slave (
        input  baseValid, base, baseN, sop, eop, kmerReady,
        output baseReady, kmer, kmerValid, kmerPos, readDone, readKmerCount, protocolError
    );
endinterface

// File: rtl/kmer_window_reg.sv
// Sliding base window; with CANONICAL_KMER_EN defined it also tracks the reverse
// complement and outputs the smaller of the two.
module kmer_window_reg
    import kmer_pkg::*;
#(
    parameter int unsigned KMER_WIDTH = 45
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shiftEn,
    input  logic [1:0]              baseIn,
    output logic [2*KMER_WIDTH-1:0] kmerOut
);
    logic [2*KMER_WIDTH-1:0] fwdQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwdQ <= '0;
        end else if (shiftEn) begin
            fwdQ <= {fwdQ[2*KMER_WIDTH-3:0], baseIn};
        end
    end

`ifdef CANONICAL_KMER_EN
    logic [2*KMER_WIDTH-1:0] rcQ;

    // Complement enters at the top so rcQ always equals revcomp(fwdQ).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcQ <= '0;
        end else if (shiftEn) begin
            rcQ <= {revcomp_base(baseIn), rcQ[2*KMER_WIDTH-1:2]};
        end
    end

    assign kmerOut = (rcQ < fwdQ) ? rcQ : fwdQ;
`else
    assign kmerOut = fwdQ;
`endif

endmodule

// File: rtl/kmer_extractor.sv
// Frames a 2-bit base stream into per-read k-mers with positions and per-read counts.
// Define CANONICAL_KMER_EN to emit canonical (min of forward / reverse-complement) k-mers.
module kmer_extractor
    import kmer_pkg::*;
#(
    parameter int unsigned KMER_WIDTH = 45,
    parameter int unsigned POS_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst,
    kmer_extractor_if.slave  bus
);
    localparam int unsigned    CntW    = $clog2(KMER_WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(KMER_WIDTH);

    kmerState_t           stateQ, stateD;
    logic [CntW-1:0]      winCntQ, winCntD;
    logic [POS_WIDTH-1:0] basePosQ, basePosD;
    logic [POS_WIDTH-1:0] kmerCntQ, kmerCntD;
    logic                 kmerValidQ, kmerValidD;
    logic [POS_WIDTH-1:0] kmerPosQ, kmerPosD;
    logic                 readDoneQ, readDoneD;
    logic [POS_WIDTH-1:0] readKmerCountQ, readKmerCountD;
    logic                 protoErrQ, protoErrD;

    logic                 baseReady;
    logic                 accept;
    logic                 shiftEn;
    logic                 emit;
    logic [CntW-1:0]      curCnt;
    logic [POS_WIDTH-1:0] curPos;
    logic [POS_WIDTH-1:0] curKmers;

    kmer_window_reg #(
        .KMER_WIDTH (KMER_WIDTH)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .shiftEn (shiftEn),
        .baseIn  (bus.base),
        .kmerOut (bus.kmer)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ         <= IDLE;
            winCntQ        <= '0;
            basePosQ       <= '0;
            kmerCntQ       <= '0;
            kmerValidQ     <= 1'b0;
            kmerPosQ       <= '0;
            readDoneQ      <= 1'b0;
            readKmerCountQ <= '0;
            protoErrQ      <= 1'b0;
        end else begin
            stateQ         <= stateD;
            winCntQ        <= winCntD;
            basePosQ       <= basePosD;
            kmerCntQ       <= kmerCntD;
            kmerValidQ     <= kmerValidD;
            kmerPosQ       <= kmerPosD;
            readDoneQ      <= readDoneD;
            readKmerCountQ <= readKmerCountD;
            protoErrQ      <= protoErrD;
        end
    end

    always_comb begin
        stateD         = stateQ;
        winCntD        = winCntQ;
        basePosD       = basePosQ;
        kmerCntD       = kmerCntQ;
        kmerValidD     = kmerValidQ;
        kmerPosD       = kmerPosQ;
        readDoneD      = 1'b0;
        readKmerCountD = readKmerCountQ;
        protoErrD      = protoErrQ;
        shiftEn        = 1'b0;
        emit           = 1'b0;
        curCnt         = winCntQ;
        curPos         = basePosQ;
        curKmers       = kmerCntQ;

        baseReady = ~kmerValidQ | bus.kmerReady;
        accept    = bus.baseValid & baseReady;

        if (kmerValidQ && bus.kmerReady) begin
            kmerValidD = 1'b0;
        end

        if (accept) begin
            if (stateQ == IDLE && !bus.sop) begin
                protoErrD = 1'b1;
            end else begin
                // A new sop restarts the read even if one is in flight.
                if (bus.sop) begin
                    if (stateQ != IDLE) begin
                        protoErrD = 1'b1;
                    end
                    curCnt   = '0;
                    curPos   = '0;
                    curKmers = '0;
                end

                basePosD = (curPos == '1) ? curPos : curPos + POS_WIDTH'(1);

                if (bus.baseN) begin
                    winCntD = '0;
                    stateD  = FILL;
                end else begin
                    shiftEn = 1'b1;
                    winCntD = (curCnt == CntFull) ? CntFull : curCnt + CntW'(1);
                    if (winCntD == CntFull) begin
                        emit   = 1'b1;
                        stateD = STREAM;
                    end else begin
                        stateD = FILL;
                    end
                end

                kmerCntD = curKmers;
                if (emit) begin
                    kmerCntD   = (curKmers == '1) ? curKmers : curKmers + POS_WIDTH'(1);
                    kmerValidD = 1'b1;
                    kmerPosD   = curPos - POS_WIDTH'(KMER_WIDTH - 1);
                end

                if (bus.eop) begin
                    readDoneD      = 1'b1;
                    readKmerCountD = kmerCntD;
                    stateD         = IDLE;
                end
            end
        end
    end

    assign bus.baseReady     = baseReady;
    assign bus.kmerValid     = kmerValidQ;
    assign bus.kmerPos       = kmerPosQ;
    assign bus.readDone      = readDoneQ;
    assign bus.readKmerCount = readKmerCountQ;
    assign bus.protocolError = protoErrQ;

endmodule

// File: tb/tb_kmer_extractor.sv
// Directed bench for kmer_extractor with K=4; expected k-mers are hand-computed and
// identical in forward and canonical builds.
module tb_kmer_extractor;
    import kmer_pkg::*;

    localparam int unsigned K  = 4;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    kmer_extractor_if #(.KMER_WIDTH(K), .POS_WIDTH(PW)) bus ();

    kmer_extractor #(
        .KMER_WIDTH (K),
        .POS_WIDTH  (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] expKmerQ[$];
    logic [7:0] expPosQ[$];
    logic [7:0] expCntQ[$];

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each handshake and each readDone is checked once, mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.kmerValid && bus.kmerReady) begin
            checkEq("kmerAvail", 64'(expKmerQ.size() > 0), 1);
            if (expKmerQ.size() > 0) begin
                checkEq("kmer", bus.kmer, expKmerQ.pop_front());
                checkEq("kmerPos", bus.kmerPos, expPosQ.pop_front());
            end
        end
        if (!rst && bus.readDone) begin
            checkEq("doneAvail", 64'(expCntQ.size() > 0), 1);
            if (expCntQ.size() > 0) begin
                checkEq("readKmerCount", bus.readKmerCount, expCntQ.pop_front());
            end
        end
    end

    function automatic logic [1:0] baseCode(input byte c);
        case (c)
            "C":     return BASE_C;
            "G":     return BASE_G;
            "T":     return BASE_T;
            default: return BASE_A;
        endcase
    endfunction

    task automatic sendBeat(input byte c, input logic s, input logic e);
        int   waitCycles = 0;
        logic took;
        bus.baseValid = 1'b1;
        bus.base      = baseCode(c);
        bus.baseN     = (c == "N");
        bus.sop       = s;
        bus.eop       = e;
        do begin
            @(negedge clk);
            took = bus.baseReady;
            @(posedge clk);
            #1;
            waitCycles++;
        end while (!took && waitCycles < 100);
        checkEq("beatAccept", took, 1);
        bus.baseValid = 1'b0;
        bus.sop       = 1'b0;
        bus.eop       = 1'b0;
        bus.baseN     = 1'b0;
    endtask

    task automatic sendSeq(input string s, input logic doSop, input logic doEop);
        for (int i = 0; i < s.len(); i++) begin
            sendBeat(s[i], doSop && (i == 0), doEop && (i == s.len() - 1));
        end
    endtask

    task automatic pushKmer(input logic [7:0] k, input logic [7:0] p);
        expKmerQ.push_back(k);
        expPosQ.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic runAcgta();
        pushKmer(8'h1B, 8'd0);
        pushKmer(8'h6C, 8'd1);
        expCntQ.push_back(8'd2);
        sendSeq("ACGTA", 1'b1, 1'b1);
        idle(3);
    endtask

    initial begin
        bus.baseValid = 1'b0;
        bus.base      = BASE_A;
        bus.baseN     = 1'b0;
        bus.sop       = 1'b0;
        bus.eop       = 1'b0;
        bus.kmerReady = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        checkEq("rstKmerValid", bus.kmerValid, 0);
        checkEq("rstReadDone", bus.readDone, 0);
        checkEq("rstProtoErr", bus.protocolError, 0);
        checkEq("rstKmer", bus.kmer, 0);
        checkEq("rstKmerPos", bus.kmerPos, 0);
        checkEq("rstCount", bus.readKmerCount, 0);
        checkEq("rstBaseReady", bus.baseReady, 1);

        runAcgta();

        // N flushes the window; only GTAC (last base at offset 6) completes.
        pushKmer(8'hB1, 8'd3);
        expCntQ.push_back(8'd1);
        sendSeq("ACNGTAC", 1'b1, 1'b1);
        idle(3);

        // Short read: readDone right after the eop beat, count 0, one cycle wide.
        expCntQ.push_back(8'd0);
        sendSeq("ACG", 1'b1, 1'b1);
        checkEq("shortDoneLat", bus.readDone, 1);
        checkEq("shortNoKmer", bus.kmerValid, 0);
        idle(1);
        checkEq("shortDonePulse", bus.readDone, 0);
        idle(2);

        // Backpressure: first k-mer held 5 cycles with baseReady low.
        bus.kmerReady = 1'b0;
        for (int i = 0; i < 4; i++) pushKmer(8'h00, 8'(i));
        expCntQ.push_back(8'd4);
        fork
            sendSeq("AAAAAAA", 1'b1, 1'b1);
            begin
                int guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!bus.kmerValid && guard < 50);
                checkEq("stallSeenValid", bus.kmerValid, 1);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    checkEq("stallKmer", bus.kmer, 8'h00);
                    checkEq("stallPos", bus.kmerPos, 8'd0);
                    checkEq("stallBaseReady", bus.baseReady, 0);
                    checkEq("stallValid", bus.kmerValid, 1);
                end
                @(posedge clk);
                #1 bus.kmerReady = 1'b1;
            end
        join
        idle(3);

        // Beat without sop in IDLE is dropped and flags an error.
        sendBeat("A", 1'b0, 1'b0);
        idle(1);
        checkEq("dropProtoErr", bus.protocolError, 1);
        checkEq("dropNoKmer", bus.kmerValid, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        idle(1);
        checkEq("errClearedByRst", bus.protocolError, 0);

        // sop mid-read abandons the first read without a readDone.
        pushKmer(8'h1B, 8'd0);
        sendSeq("ACGT", 1'b1, 1'b0);
        pushKmer(8'hB1, 8'd0);
        expCntQ.push_back(8'd1);
        sendSeq("GTAC", 1'b1, 1'b1);
        idle(1);
        checkEq("midSopProtoErr", bus.protocolError, 1);
        idle(2);

        // Reset mid-STREAM with a k-mer pending and a beat stalled behind it.
        bus.kmerReady = 1'b0;
        sendSeq("AAAA", 1'b1, 1'b0);
        bus.baseValid = 1'b1;
        bus.base      = BASE_C;
        @(negedge clk);
        checkEq("preRstValid", bus.kmerValid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkEq("midRstValid", bus.kmerValid, 0);
        checkEq("midRstDone", bus.readDone, 0);
        checkEq("midRstPos", bus.kmerPos, 0);
        checkEq("midRstCount", bus.readKmerCount, 0);
        checkEq("midRstProtoErr", bus.protocolError, 0);
        bus.baseValid = 1'b0;
        bus.kmerReady = 1'b1;
        @(negedge clk) rst = 1'b0;
        idle(1);

        runAcgta();

        checkEq("kmersLeft", 64'(expKmerQ.size()), 0);
        checkEq("donesLeft", 64'(expCntQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/kmer_extractor.md
Name: kmer_extractor

Overview:
- Upstream feeder for the counting-Bloom-filter wrapper.
- Converts a stream of 2-bit bases, one per beat and framed per read, into a sliding window of KMER_WIDTH bases.
- Emits one k-mer per base once the window is full; the k-mer drives the wrapper's kmer/ipValid inputs.
- Ambiguous bases ('N') flush the window; per-read k-mer counts are reported at end of read.

Parameters:
- KMER_WIDTH, 45, bases per k-mer; k-mer bus is 2*KMER_WIDTH bits.
- POS_WIDTH, 16, width of base position / k-mer count counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- baseValid  in  1  base beat valid.
- baseReady  out  1  beat accepted when baseValid & baseReady.
- base  in  2  A=00 C=01 G=10 T=11.
- baseN  in  1  beat is ambiguous; base is ignored.
- sop  in  1  first beat of read.
- eop  in  1  last beat of read.
- kmer  out  2*KMER_WIDTH  k-mer; newest base in bits [1:0].
- kmerValid  out  1  k-mer valid.
- kmerReady  in  1  downstream accepts; tied to wrapper ready.
- kmerPos  out  POS_WIDTH  read offset of the k-mer's first base.
- readDone  out  1  one-cycle pulse after eop is processed.
- readKmerCount  out  POS_WIDTH  k-mers emitted for the finished read; valid with readDone.
- protocolError  out  1  sticky flag; cleared only by rst.

Behaviour:
- Reset: all outputs 0; state IDLE; window, counters and reverse-complement register cleared. Reset mid-read drops the read and any pending k-mer.
- Handshake: baseReady = ~kmerValid | kmerReady (single output register, no bubble). kmerValid holds and kmer/kmerPos stay stable until kmerReady.
- States:
  - IDLE: beats without sop are dropped; they are accepted and set protocolError. An accepted sop moves to FILL, clears the window count and base position, then processes the beat.
  - FILL: window count < KMER_WIDTH. Each accepted beat shifts the base in, increments the count and increments the base position. When the count reaches KMER_WIDTH, move to STREAM and emit.
  - STREAM: every accepted non-N beat shifts the window and emits. kmerPos = basePos - KMER_WIDTH + 1.
- Latency: the k-mer appears in the cycle after its last base is accepted.
- Shift rule: window <= {window[2K-3:0], base}. The reverse complement is maintained incrementally: rc <= {~base, rc[2K-1:2]}.
- N base: window count := 0; state := FILL; base position still increments; no emit.
- eop:
  - The beat is processed first.
  - The next cycle pulses readDone with readKmerCount, counting this beat's k-mer if any.
  - State returns to IDLE.
  - sop&eop on one beat is a 1-base read.
  - A read shorter than KMER_WIDTH gives readDone with count 0.
- sop while in FILL or STREAM: sets protocolError; the previous read is abandoned with no readDone; the new read starts.
- Counters saturate at all-ones; no wrap.
- kmerReady low with beats pending: baseReady low and nothing is lost. A readDone pulse is not held back by kmerReady.

Optional Feature:
- Macro CANONICAL_KMER_EN.
- Defined: kmer is the unsigned minimum of the forward window and its reverse complement, both taken after the shift and registered together. Latency is unchanged.
- Undefined: kmer is the forward window; the rc register is not instantiated.

Decomposition:
- Package kmer_pkg: base encodings (BASE_A/C/G/T), state enum (IDLE, FILL, STREAM), function revcomp_base.
- Sub-module kmer_window_reg: shift register plus optional rc register and min comparator.
- FSM, counters and handshake stay in the top module.

Test Plan (K=4, POS_WIDTH=8 unless noted):
- Read ACGTA, sop on A, eop on final A, kmerReady=1 → kmers 0x1B (pos 0), 0x6C (pos 1); readDone with count 2. With CANONICAL_KMER_EN → 0x1B, 0x6C (rc of CGTA is 0xC6).
- Read ACNGTAC → no kmer until GTAC = 0xB1 at pos 3; readDone count 1.
- Read ACG (3 bases) → no kmerValid; readDone count 0, one cycle after eop beat.
- Read AAAAAAA with kmerReady low for 5 cycles after the first kmer → baseReady low; kmer 0x00 pos 0 held stable; after release, pos 1,2,3 emitted in order; count 4.
- Beat without sop in IDLE → dropped, protocolError=1. Then sop mid-read → new read starts, old read gives no readDone.
- rst asserted mid-STREAM with kmerValid=1 → kmerValid, readDone, counters 0 next edge. A following clean read behaves as in the first scenario.
